mem_port_arbiter: RTL and testbench

//  Shares one single-outstanding memory bus port between instruction fetch (imem) and

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding bus port between fetch (imem) and data (dmem).
// Optional starve guard under `MEM_ARB_STARVE_GUARD_EN`.
//
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   imem_*        : fetch request/addr in; gnt/rvalid/rdata out
//   dmem_*        : data request/we/be/addr/wdata in; gnt/rvalid/rdata out
//   bus_*         : unified memory bus; req/we/be/addr/wdata out,
//                   gnt/rvalid/rdata in
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            imem_req_i,
  input  logic [AW-1:0]   imem_addr_i,
  output logic            imem_gnt_o,
  output logic            imem_rvalid_o,
  output logic [DW-1:0]   imem_rdata_o,
  input  logic            dmem_req_i,
  input  logic            dmem_we_i,
  input  logic [DW/8-1:0] dmem_be_i,
  input  logic [AW-1:0]   dmem_addr_i,
  input  logic [DW-1:0]   dmem_wdata_i,
  output logic            dmem_gnt_o,
  output logic            dmem_rvalid_o,
  output logic [DW-1:0]   dmem_rdata_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_be_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [DW-1:0]   bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } state_e;

  state_e state_q, state_d;

  logic            starve;
  logic            sel_d;
  logic            any_req;

  logic            i_gnt, i_rvalid;
  logic [DW-1:0]   i_rdata;
  logic            d_gnt, d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            b_req, b_we;
  logic [DW/8-1:0] b_be;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign starve = imem_req_i && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (!imem_req_i || i_gnt) begin
      cnt_d = '0;
    end else if (d_gnt && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Limit only matters when the guard is built in.
  logic unused_lim;
  assign unused_lim = (STARVE_LIMIT == 0);
  assign starve     = 1'b0;
`endif

  assign any_req = imem_req_i | dmem_req_i;
  assign sel_d   = dmem_req_i & ~starve;

  always_comb begin
    state_d  = state_q;
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    b_req    = 1'b0;
    b_we     = 1'b0;
    b_be     = '0;
    b_addr   = '0;
    b_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          b_req = 1'b1;
          if (sel_d) begin
            b_we    = dmem_we_i;
            b_be    = dmem_be_i;
            b_addr  = dmem_addr_i;
            b_wdata = dmem_wdata_i;
          end else begin
            b_be    = '1;
            b_addr  = imem_addr_i;
          end
          if (bus_gnt_i) begin
            d_gnt   = sel_d;
            i_gnt   = ~sel_d;
            state_d = sel_d ? WAIT_D : WAIT_I;
          end
        end
      end
      WAIT_I: begin
        if (bus_rvalid_i) begin
          i_rvalid = 1'b1;
          i_rdata  = bus_rdata_i;
          state_d  = IDLE;
        end
      end
      WAIT_D: begin
        if (bus_rvalid_i) begin
          d_rvalid = 1'b1;
          d_rdata  = bus_rdata_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low for the whole reset window,
  // even while requests are still held by the core.
  assign imem_gnt_o    = rst_ni & i_gnt;
  assign imem_rvalid_o = rst_ni & i_rvalid;
  assign imem_rdata_o  = rst_ni ? i_rdata : '0;
  assign dmem_gnt_o    = rst_ni & d_gnt;
  assign dmem_rvalid_o = rst_ni & d_rvalid;
  assign dmem_rdata_o  = rst_ni ? d_rdata : '0;
  assign bus_req_o     = rst_ni & b_req;
  assign bus_we_o      = rst_ni & b_we;
  assign bus_be_o      = rst_ni ? b_be : '0;
  assign bus_addr_o    = rst_ni ? b_addr : '0;
  assign bus_wdata_o   = rst_ni ? b_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change after negedge; outputs sampled 1ns later.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o;
  logic        imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic        dmem_we_i;
  logic [3:0]  dmem_be_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_gnt_o;
  logic        dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_req_i   (imem_req_i),
    .imem_addr_i  (imem_addr_i),
    .imem_gnt_o   (imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o),
    .imem_rdata_o (imem_rdata_o),
    .dmem_req_i   (dmem_req_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_be_i    (dmem_be_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_gnt_o   (dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o),
    .dmem_rdata_o (dmem_rdata_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Requesters must hold req until granted.
  logic ipend = 1'b0;
  logic dpend = 1'b0;
  always @(posedge clk_i) begin
    if (rst_ni && ipend && !imem_req_i) begin
      fails++;
      $display("FAIL imem_req_drop: got 0 want 1");
    end
    if (rst_ni && dpend && !dmem_req_i) begin
      fails++;
      $display("FAIL dmem_req_drop: got 0 want 1");
    end
    ipend <= rst_ni && imem_req_i && !imem_gnt_o;
    dpend <= rst_ni && dmem_req_i && !dmem_gnt_o;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    imem_req_i   = 1'b0;
    imem_addr_i  = '0;
    dmem_req_i   = 1'b0;
    dmem_we_i    = 1'b0;
    dmem_be_i    = '0;
    dmem_addr_i  = '0;
    dmem_wdata_i = '0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h40;
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h80;
    bus_gnt_i   = 1'b1;
    tick();
    #1;
    tests++;
    if ({bus_req_o, imem_gnt_o, dmem_gnt_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 000",
               {bus_req_o, imem_gnt_o, dmem_gnt_o});
    end
    tests++;
    if (bus_addr_o !== 32'h0 || bus_be_o !== 4'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h/%h want 0/0",
               bus_addr_o, bus_be_o);
    end
    idle_inputs();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_imem_only();
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h100;
    bus_gnt_i   = 1'b1;
    #1;
    tests++;
    if (imem_gnt_o !== 1'b1 || dmem_gnt_o !== 1'b0) begin
      fails++;
      $display("FAIL imem_gnt: got %b%b want 10",
               imem_gnt_o, dmem_gnt_o);
    end
    tests++;
    if ({bus_req_o, bus_we_o, bus_be_o} !== 6'b10_1111 ||
        bus_addr_o !== 32'h100 || bus_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL imem_payload: got %b%b%h %h %h want 1 0 f 100 0",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o);
    end
    tick();
    imem_req_i   = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEADBEEF;
    #1;
    tests++;
    if (imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL imem_rsp: got %b %h want 1 deadbeef",
               imem_rvalid_o, imem_rdata_o);
    end
    tests++;
    if (dmem_rvalid_o !== 1'b0 || dmem_rdata_o !== 32'h0 ||
        bus_req_o !== 1'b0) begin
      fails++;
      $display("FAIL imem_rsp_side: got %b %h %b want 0 0 0",
               dmem_rvalid_o, dmem_rdata_o, bus_req_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_both();
    imem_req_i   = 1'b1;
    imem_addr_i  = 32'h104;
    dmem_req_i   = 1'b1;
    dmem_we_i    = 1'b1;
    dmem_be_i    = 4'b0011;
    dmem_addr_i  = 32'h2000;
    dmem_wdata_i = 32'h12345678;
    bus_gnt_i    = 1'b1;
    #1;
    tests++;
    if (dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0) begin
      fails++;
      $display("FAIL both_gnt: got d%b i%b want d1 i0",
               dmem_gnt_o, imem_gnt_o);
    end
    tests++;
    if (bus_we_o !== 1'b1 || bus_be_o !== 4'b0011 ||
        bus_addr_o !== 32'h2000 || bus_wdata_o !== 32'h12345678) begin
      fails++;
      $display("FAIL both_payload: got %b %h %h %h want 1 3 2000 12345678",
               bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o);
    end
    tick();
    dmem_req_i   = 1'b0;
    dmem_we_i    = 1'b0;
    bus_gnt_i    = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h0;
    #1;
    tests++;
    if (dmem_rvalid_o !== 1'b1 || imem_gnt_o !== 1'b0 ||
        bus_req_o !== 1'b0) begin
      fails++;
      $display("FAIL both_drsp: got rv%b ig%b rq%b want 1 0 0",
               dmem_rvalid_o, imem_gnt_o, bus_req_o);
    end
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    tests++;
    if (imem_gnt_o !== 1'b1 || bus_addr_o !== 32'h104 ||
        bus_we_o !== 1'b0) begin
      fails++;
      $display("FAIL both_igrant: got %b %h %b want 1 104 0",
               imem_gnt_o, bus_addr_o, bus_we_o);
    end
    tick();
    imem_req_i   = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE0001;
    #1;
    tests++;
    if (imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL both_irsp: got %b %h want 1 cafe0001",
               imem_rvalid_o, imem_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_gnt_stall();
    int bad = 0;
    dmem_req_i   = 1'b1;
    dmem_be_i    = 4'hF;
    dmem_addr_i  = 32'h3000;
    dmem_wdata_i = 32'h55AA55AA;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h3000 ||
          bus_wdata_o !== 32'h55AA55AA || dmem_gnt_o !== 1'b0 ||
          imem_gnt_o !== 1'b0) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    end
    bus_gnt_i = 1'b1;
    #1;
    tests++;
    if (dmem_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL stall_gnt: got %b want 1", dmem_gnt_o);
    end
    tick();
    dmem_req_i   = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h77;
    #1;
    tests++;
    if (dmem_rvalid_o !== 1'b1 || dmem_rdata_o !== 32'h77) begin
      fails++;
      $display("FAIL stall_rsp: got %b %h want 1 77",
               dmem_rvalid_o, dmem_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hAA;
    bus_gnt_i    = 1'b1;
    #1;
    tests++;
    if ({imem_rvalid_o, dmem_rvalid_o, imem_gnt_o, dmem_gnt_o} !== 4'b0 ||
        imem_rdata_o !== 32'h0 || dmem_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL spurious: got %b %h %h want 0000 0 0",
               {imem_rvalid_o, dmem_rvalid_o, imem_gnt_o, dmem_gnt_o},
               imem_rdata_o, dmem_rdata_o);
    end
    tick();
    bus_rvalid_i = 1'b0;
    imem_req_i   = 1'b1;
    imem_addr_i  = 32'h200;
    #1;
    tests++;
    if (imem_gnt_o !== 1'b1 || bus_addr_o !== 32'h200) begin
      fails++;
      $display("FAIL spurious_next: got %b %h want 1 200",
               imem_gnt_o, bus_addr_o);
    end
    tick();
    imem_req_i   = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h400;
    dmem_be_i   = 4'hF;
    bus_gnt_i   = 1'b1;
    tick();
    dmem_req_i  = 1'b0;
    bus_gnt_i   = 1'b1;
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h500;
    rst_ni      = 1'b0;
    #1;
    tests++;
    if ({bus_req_o, imem_gnt_o, dmem_gnt_o,
         imem_rvalid_o, dmem_rvalid_o} !== 5'b0 ||
        bus_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_inflight: got %b %h want 00000 0",
               {bus_req_o, imem_gnt_o, dmem_gnt_o,
                imem_rvalid_o, dmem_rvalid_o}, bus_addr_o);
    end
    tick();
    idle_inputs();
    rst_ni       = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBAD;
    #1;
    tests++;
    if (dmem_rvalid_o !== 1'b0 || dmem_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_late_rsp: got %b %h want 0 0",
               dmem_rvalid_o, dmem_rdata_o);
    end
    tick();
    bus_rvalid_i = 1'b0;
    imem_req_i   = 1'b1;
    imem_addr_i  = 32'h600;
    bus_gnt_i    = 1'b1;
    #1;
    tests++;
    if (imem_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_recover: got %b want 1", imem_gnt_o);
    end
    tick();
    imem_req_i   = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_starve();
    int  bad = 0;
    logic exp_i;
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h700;
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h800;
    dmem_be_i   = 4'hF;
    bus_gnt_i   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_rvalid_i = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_i = ((k % 5) == 4);
`else
      exp_i = 1'b0;
`endif
      #1;
      if (imem_gnt_o !== exp_i || dmem_gnt_o !== !exp_i) begin
        bad++;
        $display("FAIL starve_k%0d: got i%b d%b want i%b d%b",
                 k, imem_gnt_o, dmem_gnt_o, exp_i, !exp_i);
      end
      tick();
      bus_rvalid_i = 1'b1;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL starve_pattern: got %0d bad grants want 0", bad);
    end
    bus_rvalid_i = 1'b0;
    // Drain both requesters, dropping each only after its grant.
    for (int n = 0; n < 4 && (imem_req_i || dmem_req_i); n++) begin
      logic ig, dg;
      bus_rvalid_i = 1'b0;
      #1;
      ig = imem_gnt_o;
      dg = dmem_gnt_o;
      tick();
      if (ig) imem_req_i = 1'b0;
      if (dg) dmem_req_i = 1'b0;
      bus_rvalid_i = 1'b1;
      tick();
    end
    tests++;
    if (imem_req_i || dmem_req_i) begin
      fails++;
      $display("FAIL starve_drain: got req %b%b want 00",
               imem_req_i, dmem_req_i);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_imem_only();
    test_both();
    test_gnt_stall();
    test_spurious();
    test_reset_inflight();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
